// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction-fetch initiator for a combinational instruction ROM. The unit
// owns the program counter and drives it straight out as the ROM address. It
// captures the ROM word into a 2-entry queue and hands the instructions to
// decode with a valid/ready handshake. It also does these jobs:
//   - takes branch redirects from execute, which flush the queue,
//   - detects the halt word (all ones), stops fetching, drains the queue and
//     then reports completion.
//
// Ports
//   Clk           in   clock, all state changes on the rising edge
//   Reset_n       in   asynchronous, active-low reset
//   Start         in   level-sampled; starts fetch at StartAddr (IDLE/HALT only)
//   StartAddr     in   first PC after Start
//   InstAddress   out  ROM address, equal to the PC register
//   InstIn        in   ROM data for InstAddress, same cycle
//   InstOut       out  instruction at the queue head
//   InstPC        out  address of InstOut
//   InstValid     out  queue non-empty
//   InstReady     in   decode accepts the head when InstValid & InstReady
//   BranchEn      in   redirect/flush request (RUN/DRAIN only)
//   BranchTarget  in   redirect address, or LUT index when the LUT is built
//   Busy          out  state is RUN or DRAIN
//   Halted        out  state is HALT
//
// Build option
//   FETCH_BRANCH_LUT_EN  adds an 8-entry branch target LUT and the ports
//                        LutWe / LutIdx / LutData. The redirect target then
//                        becomes LUT[BranchTarget[2:0]].
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int A = 10,
    parameter int W = 9
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic [A-1:0] StartAddr,
    output logic [A-1:0] InstAddress,
    input  logic [W-1:0] InstIn,
    output logic [W-1:0] InstOut,
    output logic [A-1:0] InstPC,
    output logic         InstValid,
    input  logic         InstReady,
    input  logic         BranchEn,
    input  logic [A-1:0] BranchTarget,
`ifdef FETCH_BRANCH_LUT_EN
    input  logic         LutWe,
    input  logic [2:0]   LutIdx,
    input  logic [A-1:0] LutData,
`endif
    output logic         Busy,
    output logic         Halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e       state_q, state_d;
    logic [A-1:0] pc_q, pc_d;
    logic [1:0]   count_q, count_d;

    // Queue storage. Slot 0 is always the head, so a pop shifts slot 1 down.
    logic [W-1:0] q_inst_q [2];
    logic [W-1:0] q_inst_d [2];
    logic [A-1:0] q_pc_q   [2];
    logic [A-1:0] q_pc_d   [2];

    logic         pop;
    logic         start_req;
    logic         branch_req;
    logic         has_space;
    logic         fetch;
    logic         is_halt_word;
    logic         push;
    logic         halt_hit;
    logic [1:0]   count_after_pop;
    logic [A-1:0] branch_target;

    // -----------------------------------------------------------------------
    // Redirect target resolution
    // -----------------------------------------------------------------------
`ifdef FETCH_BRANCH_LUT_EN
    logic [A-1:0] lut_q [8];
    logic         unused_target_bits;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 8; i++) begin
                lut_q[i] <= '0;
            end
        end else if (LutWe) begin
            lut_q[LutIdx] <= LutData;
        end
    end

    // The read uses the registered entries. A write to the same index in the
    // same cycle only lands at the edge, so the branch sees the old target.
    assign branch_target      = lut_q[BranchTarget[2:0]];
    assign unused_target_bits = ^BranchTarget[A-1:3];
`else
    assign branch_target = BranchTarget;
`endif

    // -----------------------------------------------------------------------
    // Handshake and fetch qualification
    // -----------------------------------------------------------------------
    assign pop          = (count_q != 2'd0) && InstReady;
    assign start_req    = Start && ((state_q == S_IDLE) || (state_q == S_HALT));
    assign branch_req   = BranchEn && ((state_q == S_RUN) || (state_q == S_DRAIN));
    // A full queue still has room when the head leaves in the same cycle.
    assign has_space    = (count_q != 2'd2) || pop;
    // A branch discards any fetch in the same cycle. This is also how a branch
    // overrides detection of the halt word.
    assign fetch        = (state_q == S_RUN) && has_space && !branch_req;
    assign is_halt_word = &InstIn;
    assign push         = fetch && !is_halt_word;
    assign halt_hit     = fetch && is_halt_word;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples the values from before the edge, whatever the
            // order of the blocks.
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: the default at the top means every path assigns state_d, so no
        // latch is inferred when a case arm leaves the state unchanged.
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start_req) state_d = S_RUN;
            end
            S_RUN: begin
                if (branch_req)    state_d = S_RUN;
                else if (halt_hit) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (branch_req)              state_d = S_RUN;
                else if (count_q == 2'd0)    state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        Busy   = 1'b0;
        Halted = 1'b0;
        unique case (state_q)
            S_RUN, S_DRAIN: Busy   = 1'b1;
            S_HALT:         Halted = 1'b1;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Program counter and queue next state
    // -----------------------------------------------------------------------
    assign count_after_pop = count_q - {1'b0, pop};

    always_comb begin
        pc_d        = pc_q;
        count_d     = count_q;
        q_inst_d[0] = q_inst_q[0];
        q_inst_d[1] = q_inst_q[1];
        q_pc_d[0]   = q_pc_q[0];
        q_pc_d[1]   = q_pc_q[1];

        if (start_req) begin
            pc_d    = StartAddr;
            count_d = 2'd0;
        end else if (branch_req) begin
            // Flush. A head popped in this cycle still counts as accepted.
            pc_d    = branch_target;
            count_d = 2'd0;
        end else begin
            if (pop) begin
                q_inst_d[0] = q_inst_q[1];
                q_pc_d[0]   = q_pc_q[1];
            end
            if (push) begin
                // After a pop the free slot is at index count_after_pop. It is
                // always 0 or 1 here, because a push needs room.
                if (count_after_pop == 2'd0) begin
                    q_inst_d[0] = InstIn;
                    q_pc_d[0]   = pc_q;
                end else begin
                    q_inst_d[1] = InstIn;
                    q_pc_d[1]   = pc_q;
                end
                pc_d = pc_q + A'(1);
            end
            count_d = count_after_pop + {1'b0, push};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q    <= '0;
            count_q <= 2'd0;
            // NOTE: the queue slots get a reset because slot 0 drives
            // InstOut/InstPC directly, and those outputs must read zero after
            // reset.
            for (int i = 0; i < 2; i++) begin
                q_inst_q[i] <= '0;
                q_pc_q[i]   <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            for (int i = 0; i < 2; i++) begin
                q_inst_q[i] <= q_inst_d[i];
                q_pc_q[i]   <= q_pc_d[i];
            end
        end
    end

    assign InstAddress = pc_q;
    assign InstOut     = q_inst_q[0];
    assign InstPC      = q_pc_q[0];
    assign InstValid   = (count_q != 2'd0);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
//
// Self-checking bench for inst_fetch_unit. A behavioural ROM feeds InstIn
// combinationally from InstAddress. A cycle table covers straight-line fetch,
// the halt drain and back-pressure. Hand-written sequences cover the flush,
// branch-versus-halt, async reset, PC wrap, Start being ignored in RUN and,
// when FETCH_BRANCH_LUT_EN is defined, the branch target LUT.
// ---------------------------------------------------------------------------
module tb_inst_fetch_unit;

    localparam int A = 10;
    localparam int W = 9;

    logic         Clk = 1'b0;
    logic         Reset_n;
    logic         Start;
    logic [A-1:0] StartAddr;
    logic [A-1:0] InstAddress;
    logic [W-1:0] InstIn;
    logic [W-1:0] InstOut;
    logic [A-1:0] InstPC;
    logic         InstValid;
    logic         InstReady;
    logic         BranchEn;
    logic [A-1:0] BranchTarget;
    logic         Busy;
    logic         Halted;
`ifdef FETCH_BRANCH_LUT_EN
    logic         LutWe;
    logic [2:0]   LutIdx;
    logic [A-1:0] LutData;
`endif

    logic [W-1:0] rom [1024];
    assign InstIn = rom[InstAddress];

    always #5 Clk = ~Clk;

    inst_fetch_unit #(.A(A), .W(W)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .StartAddr    (StartAddr),
        .InstAddress  (InstAddress),
        .InstIn       (InstIn),
        .InstOut      (InstOut),
        .InstPC       (InstPC),
        .InstValid    (InstValid),
        .InstReady    (InstReady),
        .BranchEn     (BranchEn),
        .BranchTarget (BranchTarget),
`ifdef FETCH_BRANCH_LUT_EN
        .LutWe        (LutWe),
        .LutIdx       (LutIdx),
        .LutData      (LutData),
`endif
        .Busy         (Busy),
        .Halted       (Halted)
    );

    int n_total  = 0;
    int n_passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Checks the visible state. InstOut/InstPC are only compared when the
    // head is expected to be valid.
    task automatic expect_state(input string tag, input logic ev, input logic [W-1:0] eo,
                                input logic [A-1:0] ep, input logic [A-1:0] ea,
                                input logic eb, input logic eh);
        check({tag, ".valid"},  32'(InstValid),   32'(ev));
        check({tag, ".addr"},   32'(InstAddress), 32'(ea));
        check({tag, ".busy"},   32'(Busy),        32'(eb));
        check({tag, ".halted"}, 32'(Halted),      32'(eh));
        if (ev) begin
            check({tag, ".out"}, 32'(InstOut), 32'(eo));
            check({tag, ".pc"},  32'(InstPC),  32'(ep));
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge, and outputs are
    // sampled at that same point.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic         start;
        logic [A-1:0] sa;
        logic         ready;
        logic         ev;
        logic [W-1:0] eo;
        logic [A-1:0] ep;
        logic [A-1:0] ea;
        logic         eb;
        logic         eh;
    } vec_t;

    vec_t vecs [17];

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'h0AA;
        rom[10'h000] = 9'h001;
        rom[10'h001] = 9'h002;
        rom[10'h002] = 9'h003;
        rom[10'h003] = 9'h1FF;
        rom[10'h100] = 9'h055;
        rom[10'h101] = 9'h056;
        rom[10'h102] = 9'h1FF;
        rom[10'h3FE] = 9'h011;
        rom[10'h3FF] = 9'h012;

        // Each row holds {start, StartAddr, ready, valid, out, pc, addr, busy, halted}.
        // The expected values apply after the edge.
        // Rows 0-6: straight run with ready high, then halt and drain.
        vecs[0]  = '{1'b1, 10'h000, 1'b1, 1'b0, 9'h000, 10'h000, 10'h000, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 10'h000, 1'b1, 1'b1, 9'h001, 10'h000, 10'h001, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 10'h000, 1'b1, 1'b1, 9'h002, 10'h001, 10'h002, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 10'h000, 1'b1, 1'b1, 9'h003, 10'h002, 10'h003, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 10'h000, 1'b1, 1'b0, 9'h000, 10'h000, 10'h003, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 10'h000, 1'b1, 1'b0, 9'h000, 10'h000, 10'h003, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 10'h000, 1'b1, 1'b0, 9'h000, 10'h000, 10'h003, 1'b0, 1'b1};
        // Rows 7-16: restart from HALT, stall for several cycles, then release.
        vecs[7]  = '{1'b1, 10'h000, 1'b0, 1'b0, 9'h000, 10'h000, 10'h000, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 10'h000, 1'b0, 1'b1, 9'h001, 10'h000, 10'h001, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 10'h000, 1'b0, 1'b1, 9'h001, 10'h000, 10'h002, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 10'h000, 1'b0, 1'b1, 9'h001, 10'h000, 10'h002, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 10'h000, 1'b0, 1'b1, 9'h001, 10'h000, 10'h002, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 10'h000, 1'b0, 1'b1, 9'h001, 10'h000, 10'h002, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 10'h000, 1'b1, 1'b1, 9'h002, 10'h001, 10'h003, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 10'h000, 1'b1, 1'b1, 9'h003, 10'h002, 10'h003, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 10'h000, 1'b1, 1'b0, 9'h000, 10'h000, 10'h003, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 10'h000, 1'b1, 1'b0, 9'h000, 10'h000, 10'h003, 1'b0, 1'b1};

        Reset_n      = 1'b0;
        Start        = 1'b0;
        StartAddr    = '0;
        InstReady    = 1'b0;
        BranchEn     = 1'b0;
        BranchTarget = '0;
`ifdef FETCH_BRANCH_LUT_EN
        LutWe        = 1'b0;
        LutIdx       = '0;
        LutData      = '0;
`endif

        #12;
        expect_state("reset", 1'b0, 9'h000, 10'h000, 10'h000, 1'b0, 1'b0);
        check("reset.out", 32'(InstOut), 32'h0);
        check("reset.pc",  32'(InstPC),  32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        step();

`ifdef FETCH_BRANCH_LUT_EN
        // Index 0 maps to 0x100, so the branch sequences below land on the same
        // target in both builds.
        LutWe = 1'b1; LutIdx = 3'd0; LutData = 10'h100;
        step();
        LutWe = 1'b0;
`endif

        // ---- Table-driven part ----
        for (int i = 0; i < 17; i++) begin
            Start     = vecs[i].start;
            StartAddr = vecs[i].sa;
            InstReady = vecs[i].ready;
            step();
            expect_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eo, vecs[i].ep,
                         vecs[i].ea, vecs[i].eb, vecs[i].eh);
        end

        // ---- Branch with the queue full ----
        Start = 1'b1; StartAddr = 10'h000; InstReady = 1'b0;
        step();
        Start = 1'b0;
        step();
        step();
        expect_state("full", 1'b1, 9'h001, 10'h000, 10'h002, 1'b1, 1'b0);
        BranchEn = 1'b1; BranchTarget = 10'h100;
        step();
        BranchEn = 1'b0;
        expect_state("flush", 1'b0, 9'h000, 10'h000, 10'h100, 1'b1, 1'b0);
        step();
        expect_state("tgt0", 1'b1, 9'h055, 10'h100, 10'h101, 1'b1, 1'b0);
        InstReady = 1'b1;
        step();
        expect_state("tgt1", 1'b1, 9'h056, 10'h101, 10'h102, 1'b1, 1'b0);

        // ---- Branch in the same cycle as the halt fetch (ROM[0x102]) ----
        BranchEn = 1'b1; BranchTarget = 10'h100;
        step();
        BranchEn = 1'b0;
        expect_state("brhalt", 1'b0, 9'h000, 10'h000, 10'h100, 1'b1, 1'b0);
        step();
        expect_state("brhalt1", 1'b1, 9'h055, 10'h100, 10'h101, 1'b1, 1'b0);
        step();
        expect_state("brhalt2", 1'b1, 9'h056, 10'h101, 10'h102, 1'b1, 1'b0);
        step();
        expect_state("drain", 1'b0, 9'h000, 10'h000, 10'h102, 1'b1, 1'b0);
        step();
        expect_state("halt2", 1'b0, 9'h000, 10'h000, 10'h102, 1'b0, 1'b1);

        // ---- Async reset mid-RUN ----
        Start = 1'b1; StartAddr = 10'h000; InstReady = 1'b0;
        step();
        Start = 1'b0;
        step();
        expect_state("prerst", 1'b1, 9'h001, 10'h000, 10'h001, 1'b1, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        expect_state("midrst", 1'b0, 9'h000, 10'h000, 10'h000, 1'b0, 1'b0);
        check("midrst.out", 32'(InstOut), 32'h0);
        check("midrst.pc",  32'(InstPC),  32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        step();
        expect_state("postrst", 1'b0, 9'h000, 10'h000, 10'h000, 1'b0, 1'b0);

        // ---- PC wrap and Start ignored while running ----
        Start = 1'b1; StartAddr = 10'h3FE; InstReady = 1'b1;
        step();
        Start = 1'b0;
        expect_state("wrap0", 1'b0, 9'h000, 10'h000, 10'h3FE, 1'b1, 1'b0);
        step();
        expect_state("wrap1", 1'b1, 9'h011, 10'h3FE, 10'h3FF, 1'b1, 1'b0);
        step();
        expect_state("wrap2", 1'b1, 9'h012, 10'h3FF, 10'h000, 1'b1, 1'b0);
        Start = 1'b1; StartAddr = 10'h200;
        step();
        expect_state("wrap3", 1'b1, 9'h001, 10'h000, 10'h001, 1'b1, 1'b0);
        Start = 1'b0;
        step();
        expect_state("ignstart", 1'b1, 9'h002, 10'h001, 10'h002, 1'b1, 1'b0);

`ifdef FETCH_BRANCH_LUT_EN
        // ---- Branch target LUT ----
        LutWe = 1'b1; LutIdx = 3'd5; LutData = 10'h040;
        step();
        expect_state("lutwr", 1'b1, 9'h003, 10'h002, 10'h003, 1'b1, 1'b0);
        // This write to index 5 lands at the same edge as the branch, so the
        // branch still uses the old entry 0x040.
        LutData = 10'h080; BranchEn = 1'b1; BranchTarget = 10'h005;
        step();
        LutWe = 1'b0; BranchEn = 1'b0;
        expect_state("lutbr", 1'b0, 9'h000, 10'h000, 10'h040, 1'b1, 1'b0);
        step();
        expect_state("luttgt", 1'b1, 9'h0AA, 10'h040, 10'h041, 1'b1, 1'b0);
        // The upper bits of BranchTarget are ignored, so 0x3FD selects entry 5.
        BranchEn = 1'b1; BranchTarget = 10'h3FD;
        step();
        BranchEn = 1'b0;
        expect_state("lutnew", 1'b0, 9'h000, 10'h000, 10'h080, 1'b1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction-fetch initiator for the instruction ROM. It owns the program counter and drives the ROM address. It captures the combinational ROM data into a 2-entry queue and presents instructions to decode with a valid/ready handshake. It also handles branch redirects and detects the halt word, stopping fetch and reporting completion.

## Interface
- A, 10, instruction address width (ROM depth 2**A)
- W, 9, instruction width; halt word is all-ones of W bits
- Clk  in  1  clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  level-sampled request; begins fetch at StartAddr
- StartAddr  in  A  first PC after Start
- InstAddress  out  A  address to ROM, equals PC register (combinational from flop)
- InstIn  in  W  ROM data for InstAddress, same cycle
- InstOut  out  W  instruction at queue head
- InstPC  out  A  address of InstOut
- InstValid  out  1  queue non-empty
- InstReady  in  1  decode accepts head when InstValid&InstReady
- BranchEn  in  1  redirect/flush request from execute
- BranchTarget  in  A  redirect address (see Configuration)
- Busy  out  1  state is RUN or DRAIN
- Halted  out  1  state is HALT

## Operation
- States: IDLE, RUN, DRAIN, HALT. Reset → IDLE.
- IDLE/HALT: Start=1 → PC=StartAddr, queue cleared, → RUN. BranchEn ignored.
- RUN: each cycle fetch occurs if queue has space (count<2, or count==2 with pop this cycle).
  - Fetch of non-halt word: enqueue {InstIn, PC}; PC=PC+1 mod 2**A (2**A-1 wraps to 0).
  - Fetch of halt word (InstIn all-ones): not enqueued; PC holds; → DRAIN.
  - No space: PC holds, nothing enqueued.
- DRAIN: no fetch; pops continue; count==0 → HALT.
- BranchEn=1 in RUN or DRAIN: queue flushed, any same-cycle fetch discarded, PC=resolved target, → RUN. A pop in that cycle still counts as accepted. Branch beats halt detection in the same cycle.
- Start in RUN/DRAIN: ignored.
- Queue: 2 entries, FIFO order, simultaneous push and pop allowed at any count; count never exceeds 2 or goes below 0.
- InstOut/InstPC hold value while InstValid=1 and InstReady=0.

## Timing
- Reset values: PC=0 (InstAddress=0), InstOut=0, InstPC=0, InstValid=0, Busy=0, Halted=0, count=0.
- Start sampled at edge k → InstAddress=StartAddr after k → first InstValid=1 after edge k+1 (1-cycle fetch latency).
- Sustained throughput: 1 instruction/cycle with InstReady held high.
- Branch sampled at edge k → InstValid=0 after k → target instruction valid after edge k+1.
- Halt fetched at edge k with empty queue → Halted=1 after edge k+1 (DRAIN lasts ≥1 cycle).
- Reset_n low mid-operation: all state returns to reset values immediately (async), regardless of state.

## Configuration
- FETCH_BRANCH_LUT_EN defined: adds an 8-entry × A-bit branch target LUT with extra ports LutWe (in 1), LutIdx (in 3), LutData (in A). Writes occur on the rising edge when LutWe=1; all entries reset to 0. Redirect target = LUT[BranchTarget[2:0]]; upper BranchTarget bits are ignored. A LUT write and a branch reading the same index in one cycle uses the old entry.
- Not defined: no LUT and no extra ports; redirect target = BranchTarget directly.

## Test plan
- Reset then Start, StartAddr=0, ROM 0..3 = 0x001,0x002,0x003,0x1FF, InstReady=1 → InstOut 0x001,0x002,0x003 with InstPC 0,1,2 on consecutive cycles; Halted=1 the cycle after 0x003 is accepted; the halt word is never output.
- Same program, InstReady=0 for 5 cycles → queue holds 0x001,0x002; InstAddress stays 2; no loss or duplication after release.
- BranchEn with BranchTarget=0x100 while count=2 → both entries flushed; next valid InstPC=0x100.
- Branch in the same cycle as halt fetch → no DRAIN; fetch resumes at target; Busy stays 1.
- StartAddr=0x3FE, no halt → InstPC sequence 0x3FE,0x3FF,0x000.
- With FETCH_BRANCH_LUT_EN: write LUT[5]=0x040, then branch with BranchTarget=5 → next InstPC=0x040. Mid-RUN Reset_n pulse → all outputs zero, state IDLE.
